// File: rtl/ir_fetch.sv
// Instruction fetch unit.
// It issues one read at a time to instruction memory and holds the returned word
// in an instruction register until the execute stage accepts it.
// In the first hold cycle it tells the program counter what to do next:
// a JAL word produces a load pulse carrying the jump target; any other word
// produces a single advance pulse.
// A flush drops the current instruction. A response that is still outstanding
// when the flush arrives is drained and discarded.
module ir_fetch #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_en,
  output logic              load,
  output logic [ADDR_W-1:0] ir_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              flush
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0]   ir_out_q, ir_out_d;
  logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
  logic                ir_valid_q, ir_valid_d;
  logic                pc_en_q, pc_en_d;
  logic                load_q, load_d;
  logic [ADDR_W-1:0]   ir_addr_q, ir_addr_d;
  logic                mem_req_q, mem_req_d;

  // Word offset of a JAL, taken from the incoming response. It is added modulo 2^ADDR_W.
  logic [12:0]         jal_off;
  logic                rdata_is_jal;

  // Decode the arriving word so the pulse is ready on the first hold cycle.
  always_comb begin
    jal_off      = {mem_rdata[14:12], mem_rdata[20], mem_rdata[30:22]};
    rdata_is_jal = (mem_rdata[6:0] == 7'b1101111);
  end

  // Next-state and next-output logic. The pulses and the jump target default low every cycle.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ir_out_d   = ir_out_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    pc_en_d    = 1'b0;
    load_d     = 1'b0;
    ir_addr_d  = {ADDR_W{1'b0}};
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (flush) begin
          ir_valid_d = 1'b0;
          state_d    = REQ;
        end else if (mem_gnt) begin
          fetch_pc_d = pc_addr;
          state_d    = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (flush) begin
          // The response is dropped if it arrives with the flush. Otherwise it is drained later.
          ir_valid_d = 1'b0;
          if (mem_rvalid) begin
            state_d = REQ;
          end else begin
            state_d = DRAIN;
          end
        end else if (mem_rvalid) begin
          ir_out_d   = mem_rdata;
          ir_pc_d    = fetch_pc_q;
          ir_valid_d = 1'b1;
          state_d    = HOLD;
          if (rdata_is_jal) begin
            load_d    = 1'b1;
            ir_addr_d = fetch_pc_q + ADDR_W'(jal_off);
          end else begin
            pc_en_d = 1'b1;
          end
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (flush) begin
          ir_valid_d = 1'b0;
          state_d    = REQ;
        end else if (ir_valid_q && ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        if (mem_rvalid) begin
          state_d = REQ;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        ir_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
    mem_req_d = (state_d == REQ);
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= {ADDR_W{1'b0}};
      ir_out_q   <= {DATA_W{1'b0}};
      ir_pc_q    <= {ADDR_W{1'b0}};
      ir_valid_q <= 1'b0;
      pc_en_q    <= 1'b0;
      load_q     <= 1'b0;
      ir_addr_q  <= {ADDR_W{1'b0}};
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ir_out_q   <= ir_out_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      pc_en_q    <= pc_en_d;
      load_q     <= load_d;
      ir_addr_q  <= ir_addr_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign pc_en    = pc_en_q;
  assign load     = load_q;
  assign ir_addr  = ir_addr_q;
  assign mem_req  = mem_req_q;
  // The program counter only changes right after a pulse, so it is stable while requesting.
  assign mem_addr = pc_addr;
  assign ir_out   = ir_out_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_ir_fetch.sv
// Testbench for ir_fetch.
// The bench plays two roles around the DUT: the program counter and the instruction memory.
// A reference model derives the expected instruction-register contents, pulses and
// jump targets directly from the fetch rules.
module tb_ir_fetch;
  localparam int AW = 13;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc_addr;
  logic          pc_en, load, mem_req, ir_valid;
  logic [AW-1:0] ir_addr, mem_addr, ir_pc;
  logic          mem_gnt, mem_rvalid, ir_ready, flush;
  logic [DW-1:0] mem_rdata, ir_out;

  int errors = 0;
  int checks = 0;
  int n_pe, n_ld;
  logic          pe_s, ld_s;
  logic [AW-1:0] ia_s;
  logic [DW-1:0] last_ir;

  ir_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .rst_n(rst_n), .pc_addr(pc_addr), .pc_en(pc_en), .load(load),
    .ir_addr(ir_addr), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ir_out(ir_out), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .flush(flush)
  );

  always #5 clock = ~clock;

  // Reference model: the opcode selects a jump.
  function automatic bit m_is_jal(input logic [31:0] w);
    return (w & 32'h0000007F) == 32'h0000006F;
  endfunction

  // Reference model: the word offset is assembled by weighting each field, then wrapped at 2^13.
  function automatic logic [AW-1:0] m_target(input logic [AW-1:0] pc, input logic [31:0] w);
    int unsigned off;
    off = ((w >> 12) & 32'd7) * 32'd1024 + ((w >> 20) & 32'd1) * 32'd512 + ((w >> 22) & 32'd511);
    return AW'((32'(pc) + off) % 32'd8192);
  endfunction

  // Advance one clock cycle.
  // The bench acts as the program counter: a pulse seen during a cycle takes
  // effect at the edge that ends that cycle.
  task automatic step();
    pe_s = pc_en; ld_s = load; ia_s = ir_addr;
    @(posedge clock); #1;
    if (pe_s) pc_addr = pc_addr + 13'd1;
    else if (ld_s) pc_addr = ia_s;
    n_pe += int'(pc_en); n_ld += int'(load);
  endtask

  // Run one complete fetch transaction.
  // gd: grant delay. rd: response delay. hd: number of stall cycles before accept.
  task automatic run_fetch(input logic [31:0] w, input int gd, input int rd, input int hd, output int cyc);
    logic [AW-1:0] exp_pc, exp_next, exp_tgt;
    bit jal;
    n_pe = 0; n_ld = 0; cyc = 0;
    jal = m_is_jal(w);
    exp_pc = pc_addr;
    exp_tgt = m_target(exp_pc, w);
    exp_next = jal ? exp_tgt : AW'((32'(exp_pc) + 32'd1) % 32'd8192);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL req_start mem_req got %b exp 1", mem_req); end
    checks++; if (mem_addr !== exp_pc) begin errors++; $display("FAIL req_addr mem_addr got %h exp %h", mem_addr, exp_pc); end
    repeat (gd) begin
      mem_gnt = 1'b0; step(); cyc++;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL req_hold mem_req got %b exp 1", mem_req); end
    end
    mem_gnt = 1'b1; step(); cyc++; mem_gnt = 1'b0;
    checks++; if (mem_req !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL wait_entry mem_req/ir_valid got %b/%b exp 0/0", mem_req, ir_valid); end
    repeat (rd) begin
      mem_gnt = 1'($urandom % 2); step(); cyc++;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wait_req mem_req got %b exp 0", mem_req); end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = w; step(); cyc++;
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    last_ir = w;
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL hold_valid ir_valid got %b exp 1", ir_valid); end
    checks++; if (ir_out !== w) begin errors++; $display("FAIL hold_ir ir_out got %h exp %h", ir_out, w); end
    checks++; if (ir_pc !== exp_pc) begin errors++; $display("FAIL hold_pc ir_pc got %h exp %h", ir_pc, exp_pc); end
    checks++; if (load !== jal || pc_en !== !jal) begin errors++; $display("FAIL pulse_kind load/pc_en got %b/%b exp %b/%b", load, pc_en, jal, !jal); end
    checks++; if (ir_addr !== (jal ? exp_tgt : 13'd0)) begin errors++; $display("FAIL ir_addr got %h exp %h", ir_addr, jal ? exp_tgt : 13'd0); end
    repeat (hd) begin
      ir_ready = 1'b0; mem_gnt = 1'($urandom % 2); mem_rvalid = 1'($urandom % 2);
      step(); cyc++;
      checks++; if (ir_out !== w || ir_pc !== exp_pc || ir_valid !== 1'b1 || mem_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold ir_out/ir_pc/valid/req got %h/%h/%b/%b exp %h/%h/1/0", ir_out, ir_pc, ir_valid, mem_req, w, exp_pc);
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; ir_ready = 1'b1; step(); cyc++; ir_ready = 1'b0;
    checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL accept valid/req got %b/%b exp 0/1", ir_valid, mem_req); end
    checks++; if (mem_addr !== exp_next) begin errors++; $display("FAIL next_pc mem_addr got %h exp %h", mem_addr, exp_next); end
    checks++; if (n_pe !== int'(!jal) || n_ld !== int'(jal)) begin errors++; $display("FAIL pulse_count pc_en/load got %0d/%0d exp %0d/%0d", n_pe, n_ld, !jal, jal); end
  endtask

  // Hold reset with the program counter at 0x0010. Every output must read 0 while reset is
  // active. After release there must be exactly one idle cycle before the first request.
  task automatic test_reset();
    rst_n = 1'b0; pc_addr = 13'h0010; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    ir_ready = 1'b0; flush = 1'b0; last_ir = 32'h0;
    #2;
    checks++; if ({pc_en, load, mem_req, ir_valid} !== 4'b0 || ir_addr !== 13'd0 || ir_out !== 32'd0 || ir_pc !== 13'd0) begin
      errors++; $display("FAIL reset_outputs pe/ld/req/valid %b%b%b%b ir_addr %h ir_out %h ir_pc %h exp all 0", pc_en, load, mem_req, ir_valid, ir_addr, ir_out, ir_pc);
    end
    @(posedge clock); #1; @(posedge clock); #1;
    rst_n = 1'b1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_idle mem_req got %b exp 0", mem_req); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 13'h0010) begin errors++; $display("FAIL reset_first_req req/addr got %b/%h exp 1/0010", mem_req, mem_addr); end
  endtask

  // A plain fetch with an immediate grant and an immediate response. It must take 3 cycles.
  task automatic test_basic();
    int cyc;
    pc_addr = 13'h0010;
    run_fetch(32'h00000013, 0, 0, 0, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL throughput cycles got %0d exp 3", cyc); end
    checks++; if (pc_addr !== 13'h0011) begin errors++; $display("FAIL basic_pc pc got %h exp 0011", pc_addr); end
  endtask

  // Jumps: a forward jump, a jump that wraps past the top of the address space,
  // and a backward jump.
  task automatic test_jal();
    int cyc;
    pc_addr = 13'h0010; run_fetch(32'h0080006F, 0, 0, 0, cyc);
    checks++; if (pc_addr !== 13'h0012) begin errors++; $display("FAIL jal_fwd pc got %h exp 0012", pc_addr); end
    pc_addr = 13'h1FFF; run_fetch(32'h0080006F, 1, 0, 0, cyc);
    checks++; if (pc_addr !== 13'h0001) begin errors++; $display("FAIL jal_wrap pc got %h exp 0001", pc_addr); end
    pc_addr = 13'h0005; run_fetch(32'hFFDFF06F, 0, 1, 0, cyc);
    checks++; if (pc_addr !== 13'h0004) begin errors++; $display("FAIL jal_back pc got %h exp 0004", pc_addr); end
  endtask

  // The execute stage holds off for five cycles before accepting.
  task automatic test_stall();
    int cyc;
    run_fetch(32'h00A00093, 1, 1, 5, cyc);
  endtask

  // Flush in WAIT with no response that cycle. The late response must be discarded,
  // and a new request must follow it.
  task automatic test_flush_drain();
    logic [AW-1:0] p0;
    p0 = pc_addr; n_pe = 0; n_ld = 0;
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL drain_entry valid/req got %b/%b exp 0/0", ir_valid, mem_req); end
    repeat (2) begin
      step();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL drain_wait mem_req got %b exp 0", mem_req); end
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; step(); mem_rvalid = 1'b0;
    checks++; if (ir_valid !== 1'b0 || ir_out !== last_ir) begin errors++; $display("FAIL drain_discard valid/ir_out got %b/%h exp 0/%h", ir_valid, ir_out, last_ir); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL drain_resume mem_req got %b exp 1", mem_req); end
    checks++; if (n_pe + n_ld !== 0 || pc_addr !== p0) begin errors++; $display("FAIL drain_pulse pulses %0d pc %h exp 0 %h", n_pe + n_ld, pc_addr, p0); end
  endtask

  // Flush in WAIT in the same cycle the response arrives. The response must be dropped.
  task automatic test_flush_wait_rvalid();
    logic [AW-1:0] p0;
    p0 = pc_addr; n_pe = 0; n_ld = 0;
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0040006F; step();
    flush = 1'b0; mem_rvalid = 1'b0;
    checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b1 || ir_out !== last_ir) begin
      errors++; $display("FAIL flush_rv valid/req/ir_out got %b/%b/%h exp 0/1/%h", ir_valid, mem_req, ir_out, last_ir);
    end
    step();
    checks++; if (n_pe + n_ld !== 0 || pc_addr !== p0) begin errors++; $display("FAIL flush_rv_pulse pulses %0d pc %h exp 0 %h", n_pe + n_ld, pc_addr, p0); end
  endtask

  // Flush in HOLD, in two variants.
  // First variant: flush in the first HOLD cycle with ready also high. Flush takes
  // priority, and the pulse already issued still counts.
  // Second variant: flush after two stall cycles.
  task automatic test_flush_hold();
    logic [AW-1:0] p0;
    p0 = pc_addr; n_pe = 0; n_ld = 0;
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h00000013; step(); mem_rvalid = 1'b0; last_ir = 32'h00000013;
    flush = 1'b1; ir_ready = 1'b1; step(); flush = 1'b0; ir_ready = 1'b0;
    checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL flush_hold1 valid/req got %b/%b exp 0/1", ir_valid, mem_req); end
    checks++; if (n_pe !== 1 || pc_addr !== p0 + 13'd1) begin errors++; $display("FAIL flush_hold1_pulse pc_en %0d pc %h exp 1 %h", n_pe, pc_addr, p0 + 13'd1); end
    p0 = pc_addr; n_pe = 0; n_ld = 0;
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0100006F; step(); mem_rvalid = 1'b0; last_ir = 32'h0100006F;
    repeat (2) step();
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL flush_hold2 valid/req got %b/%b exp 0/1", ir_valid, mem_req); end
    checks++; if (n_ld !== 1 || n_pe !== 0 || pc_addr !== m_target(p0, 32'h0100006F)) begin
      errors++; $display("FAIL flush_hold2_pulse load %0d pc_en %0d pc %h exp 1 0 %h", n_ld, n_pe, pc_addr, m_target(p0, 32'h0100006F));
    end
  endtask

  // Flush in REQ alongside a grant. The state must stay in REQ, so the grant is ignored.
  task automatic test_flush_req();
    int cyc;
    flush = 1'b1; mem_gnt = 1'b1; step(); flush = 1'b0; mem_gnt = 1'b0;
    checks++; if (mem_req !== 1'b1 || ir_valid !== 1'b0) begin errors++; $display("FAIL flush_req req/valid got %b/%b exp 1/0", mem_req, ir_valid); end
    run_fetch(32'h00310093, 0, 0, 0, cyc);
  endtask

  // A response outside a transaction must be ignored.
  task automatic test_stray_rvalid();
    n_pe = 0; n_ld = 0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0200006F; repeat (2) step(); mem_rvalid = 1'b0;
    checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b1 || ir_out !== last_ir || n_pe + n_ld !== 0) begin
      errors++; $display("FAIL stray_rvalid valid/req/ir_out/pulses got %b/%b/%h/%0d exp 0/1/%h/0", ir_valid, mem_req, ir_out, n_pe + n_ld, last_ir);
    end
  endtask

  // Reset arrives while a response is outstanding. When that response turns up after
  // release, it must be ignored.
  task automatic test_reset_mid_wait();
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    #2; rst_n = 1'b0; #1;
    checks++; if ({pc_en, load, mem_req, ir_valid} !== 4'b0 || ir_addr !== 13'd0 || ir_out !== 32'd0 || ir_pc !== 13'd0) begin
      errors++; $display("FAIL reset_mid outputs pe/ld/req/valid %b%b%b%b ir_out %h ir_pc %h exp all 0", pc_en, load, mem_req, ir_valid, ir_out, ir_pc);
    end
    last_ir = 32'h0;
    @(posedge clock); #1; rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345013;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mid_idle mem_req got %b exp 0", mem_req); end
    n_pe = 0; n_ld = 0;
    step(); mem_rvalid = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== pc_addr || ir_valid !== 1'b0 || ir_out !== 32'd0 || n_pe + n_ld !== 0) begin
      errors++; $display("FAIL reset_mid_req req/addr/valid/ir_out/pulses got %b/%h/%b/%h/%0d exp 1/%h/0/0/0", mem_req, mem_addr, ir_valid, ir_out, n_pe + n_ld, pc_addr);
    end
  endtask

  // Random mix of jumps and plain words, with random delays and occasional relocation of
  // the program counter.
  task automatic test_random();
    int cyc;
    logic [31:0] w;
    for (int i = 0; i < 40; i++) begin
      if ($urandom % 4 == 0) pc_addr = AW'($urandom);
      w = $urandom;
      if ($urandom % 2 == 0) w = {w[31:7], 7'h6F};
      else if (w[6:0] == 7'h6F) w[0] = 1'b0;
      run_fetch(w, int'($urandom % 3), int'($urandom % 4), int'($urandom % 4), cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jal();
    test_stall();
    test_flush_drain();
    test_flush_wait_rvalid();
    test_flush_hold();
    test_flush_req();
    test_stray_rvalid();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
